fp_stream_accumulator: RTL and testbench

- Downstream consumer of the single-precision multiplier. Sums a stream of its 32-bit products into one IEEE-754 single-precision result, for dot products and MAC chains.
- Operands arrive on a valid/ready input. `in_last` closes a group; the sum is then held on a valid/ready output.
- Uses a multicycle FSM with one shared adder datapath. It is not pipelined.

---
 rtl/fp_stream_accumulator.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_stream_accumulator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fp_stream_accumulator.sv
// fp_stream_accumulator
//   Sums a stream of IEEE-754 single-precision words into one result per
//   group. The datapath is multicycle and shared: IDLE -> ALIGN -> ADD ->
//   NORM (one step per cycle) [-> ROUND] -> IDLE, or DONE when the group
//   closes. Every nonzero word carries an implicit leading 1. Only
//   32'h00000000 counts as zero. No NaN, Inf or denormal handling.
//
//   Build option: FP_ACC_ROUND_EN
//     undefined : shifted-out bits are discarded (truncation).
//     defined   : guard/round/sticky bits are kept, and a ROUND state
//                 applies round-to-nearest-even.
//
//   Ports
//     clk, rst             clock (rising edge), async active-high reset
//     in_valid/in_ready    operand handshake; in_data = {s, e[7:0], f[22:0]}
//     in_last              operand closes the current group
//     out_valid/out_ready  group-sum handshake; out_data = sum
//     overflow, underflow  sticky group flags, cleared on output handshake
module fp_stream_accumulator #(
    parameter int MAX_NORM_STEPS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        overflow,
    output logic        underflow
);

`ifdef FP_ACC_ROUND_EN
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    localparam bit RND = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    localparam bit RND = 1'b0;
`endif

    localparam int CW = $clog2(MAX_NORM_STEPS + 1);

    // Mantissas are 27 bits wide: {hidden, frac[22:0], guard, round, sticky}.
    // The sum carries one extra bit on top for the carry out.
    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d, op_q, op_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, last_q, last_d;
    logic          sign_q, sign_d, sub_q, sub_d;
    logic [8:0]    exp_q, exp_d;
    logic [26:0]   big_q, big_d, sml_q, sml_d;
    logic [27:0]   sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Alignment datapath: operands are the accumulator and the latched operand.
    logic [7:0]  ea, eb, be, de;
    logic [26:0] ma, mb, bm, sm, sh;
    logic        a_big, bs, ss, lost;

    always_comb begin
        ea    = acc_q[30:23];
        eb    = op_q[30:23];
        ma    = (acc_q == 32'h0) ? 27'd0 : {1'b1, acc_q[22:0], 3'b000};
        mb    = (op_q  == 32'h0) ? 27'd0 : {1'b1, op_q[22:0], 3'b000};
        // A zero mantissa always loses the comparison, so a zero operand
        // becomes the small one and the sum reduces to the other operand.
        a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
        bm    = a_big ? ma : mb;
        sm    = a_big ? mb : ma;
        be    = a_big ? ea : eb;
        bs    = a_big ? acc_q[31] : op_q[31];
        ss    = a_big ? op_q[31] : acc_q[31];
        de    = a_big ? (ea - eb) : (eb - ea);
        if (de >= 8'd27) begin
            sh   = 27'd0;
            lost = |sm;
        end else begin
            sh   = sm >> de;
            lost = |(sm & ((27'd1 << de) - 27'd1));
        end
        if (RND) sh[0] = sh[0] | lost;
        else     sh[2:0] = 3'b000;
    end

`ifdef FP_ACC_ROUND_EN
    logic        rnd_inc;
    logic [24:0] rnd_m;
    logic [8:0]  rnd_e;
    logic [22:0] rnd_f;
    always_comb begin
        // Nearest-even: round up when guard is set and anything below it,
        // or the kept LSB, is set.
        rnd_inc = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        rnd_m   = {1'b0, sum_q[26:3]} + {24'd0, rnd_inc};
        if (rnd_m[24]) begin
            rnd_e = exp_q + 9'd1;
            rnd_f = rnd_m[23:1];
        end else begin
            rnd_e = exp_q;
            rnd_f = rnd_m[22:0];
        end
    end
`endif

    state_t nxt;
    assign nxt = last_q ? DONE : IDLE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        last_d  = last_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        big_d   = big_q;
        sml_d   = sml_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = in_data;
                last_d  = in_last;
                state_d = ALIGN;
            end
            ALIGN: begin
                big_d   = bm;
                sml_d   = sh;
                sign_d  = bs;
                sub_d   = bs ^ ss;
                exp_d   = {1'b0, be};
                state_d = ADD;
            end
            ADD: begin
                sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, sml_q})
                                : ({1'b0, big_q} + {1'b0, sml_q});
                cnt_d   = '0;
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[27]) begin
                    // Carry out: one right step, folding the lost bit into sticky.
                    sum_d = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
                    exp_d = exp_q + 9'd1;
                end else if (sum_q == 28'd0) begin
                    acc_d   = 32'h0;
                    state_d = nxt;
                end else if (!sum_q[26]) begin
                    if (exp_q <= 9'd1 || cnt_q == CW'(MAX_NORM_STEPS)) begin
                        acc_d   = 32'h0;
                        unf_d   = 1'b1;
                        state_d = nxt;
                    end else begin
                        sum_d = sum_q << 1;
                        exp_d = exp_q - 9'd1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (exp_q >= 9'd255) begin
                    acc_d   = {sign_q, 8'hFE, 23'h7FFFFF};
                    ovf_d   = 1'b1;
                    state_d = nxt;
                end else begin
`ifdef FP_ACC_ROUND_EN
                    state_d = ROUND;
`else
                    acc_d   = {sign_q, exp_q[7:0], sum_q[25:3]};
                    state_d = nxt;
`endif
                end
            end
`ifdef FP_ACC_ROUND_EN
            ROUND: begin
                if (rnd_e >= 9'd255) begin
                    acc_d = {sign_q, 8'hFE, 23'h7FFFFF};
                    ovf_d = 1'b1;
                end else begin
                    acc_d = {sign_q, rnd_e[7:0], rnd_f};
                end
                state_d = nxt;
            end
`endif
            DONE: if (out_ready) begin
                acc_d   = 32'h0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 32'h0;
            op_q    <= 32'h0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            last_q  <= 1'b0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= 9'd0;
            big_q   <= 27'd0;
            sml_q   <= 27'd0;
            sum_q   <= 28'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            last_q  <= last_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            big_q   <= big_d;
            sml_q   <= sml_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces in_ready low even though the state register sits in IDLE.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fp_stream_accumulator.sv
module tb_fp_stream_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = 32'h0;
    logic        in_ready, out_valid, overflow, underflow;
    logic [31:0] out_data;

    int nvec = 0;
    int nerr = 0;
    int lat;

`ifdef FP_ACC_ROUND_EN
    localparam int XL = 1;
    localparam logic [31:0] RND_EXP = 32'h3F800001;
`else
    localparam int XL = 0;
    localparam logic [31:0] RND_EXP = 32'h3F800000;
`endif

    fp_stream_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Handshake one operand, then count cycles until in_ready or out_valid.
    task automatic send(input logic [31:0] d, input logic l, output int n);
        int w = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        n = 0;
        while (!in_ready && !out_valid && n < 60) begin @(posedge clk); #1; n++; end
    endtask

    // Check a completed group; with out_ready high also check the flags clear.
    task automatic expect_out(input string tag, input logic [31:0] d,
                              input logic ov, input logic un);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
        chk({tag, "_unf"}, {31'd0, underflow}, {31'd0, un});
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_flags_clr"}, {30'd0, overflow, underflow}, 32'd0);
            chk({tag, "_acc_clr"}, out_data, 32'd0);
        end
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1 + 2 + 3 = 6; last add carries out (one right step)
        send(32'h3F800000, 1'b0, lat); chk("t1_lat0", lat, 3 + XL);
        send(32'h40000000, 1'b0, lat); chk("t1_lat1", lat, 3 + XL);
        send(32'h40400000, 1'b1, lat); chk("t1_lat2", lat, 4 + XL);
        expect_out("t1", 32'h40C00000, 1'b0, 1'b0);

        // 1.5 - 1.0 = 0.5; one left step
        send(32'h3FC00000, 1'b0, lat);
        send(32'hBF800000, 1'b1, lat); chk("t2_lat", lat, 4 + XL);
        expect_out("t2", 32'h3F000000, 1'b0, 1'b0);

        // exact cancellation -> +0, output held under back-pressure
        out_ready = 1'b0;
        send(32'h3F800000, 1'b0, lat);
        send(32'hBF800000, 1'b1, lat);
        expect_out("t3", 32'h00000000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_data", out_data, 32'h00000000);
            chk("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_release", {31'd0, out_valid}, 32'd0);

        // nonzero result held stable under back-pressure: 1.0 - 1.5 = -0.5
        out_ready = 1'b0;
        send(32'h3F800000, 1'b0, lat);
        send(32'hBFC00000, 1'b1, lat);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("t7_hold_data", out_data, 32'hBF000000);
        end
        out_ready = 1'b1; #1;
        expect_out("t7", 32'hBF000000, 1'b0, 1'b0);

        // exponent saturation
        send(32'h7F7FFFFF, 1'b0, lat);
        send(32'h7F7FFFFF, 1'b1, lat);
        expect_out("t4", 32'h7F7FFFFF, 1'b1, 1'b0);

        // underflow flush
        send(32'h00800000, 1'b0, lat);
        send(32'h80C00000, 1'b1, lat);
        expect_out("t5", 32'h00000000, 1'b0, 1'b1);

        // tiny addend: rounds up only with rounding enabled
        send(32'h3F800000, 1'b0, lat);
        send(32'h33C00000, 1'b1, lat);
        expect_out("t6", RND_EXP, 1'b0, 1'b0);

        // single-element group passes through, including exp-0 word
        send(32'h80000000, 1'b1, lat);
        expect_out("t8", 32'h80000000, 1'b0, 1'b0);

        // reset asserted during NORM discards the partial sum
        send(32'h3FC00000, 1'b0, lat);
        chk("t9_acc_partial", out_data, 32'h3FC00000);
        in_data = 32'hBF800000; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("t9_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t9_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t9_rst_out_data", out_data, 32'd0);
        chk("t9_rst_flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("t9_in_ready", {31'd0, in_ready}, 32'd1);
        send(32'h40000000, 1'b1, lat);
        expect_out("t9", 32'h40000000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
